// File: rtl/lift_stg2_sop_reader_pkg.sv
// -----------------------------------------------------------------------------
// lift_stg2_pkg
// Shared types and constants for the LIFT stage-2 SOP reader and related
// stages: word/residue widths, window addressing, mode encodings, the reader
// FSM state type and the checksum fold helper.
// -----------------------------------------------------------------------------
package lift_stg2_pkg;

  localparam int DW        = 63;       // stored SOP word width
  localparam int RW        = 30;       // residue width
  localparam int AW        = 3;        // word address width within a window
  localparam int MAX_WORDS = 1 << AW;  // words per window

  localparam logic MODE_RAW = 1'b0;
  localparam logic MODE_RES = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // XOR-fold of one emitted word down to residue width.
  function automatic logic [RW-1:0] chk_fold(input logic [DW-1:0] w);
    return w[29:0] ^ w[59:30] ^ {27'b0, w[62:60]};
  endfunction

endpackage

// File: rtl/lift_stg2_sop_reader_if.sv
// -----------------------------------------------------------------------------
// lift_stg2_sop_reader_if
// Valid/ready output stream of the stage-2 SOP reader.
//   M_DATA  : output word (DW bits)
//   M_VALID : word valid
//   M_READY : downstream ready
//   M_LAST  : last word of the window
//   M_WIN   : window index the word came from
// Modports: master (reader side), slave (consumer side).
// -----------------------------------------------------------------------------
interface lift_stg2_sop_reader_if;
  import lift_stg2_pkg::*;

  logic [DW-1:0] M_DATA;
  logic          M_VALID;
  logic          M_READY;
  logic          M_LAST;
  logic          M_WIN;

  modport master (output M_DATA, M_VALID, M_LAST, M_WIN, input M_READY);
  modport slave  (input M_DATA, M_VALID, M_LAST, M_WIN, output M_READY);
endinterface

// File: rtl/lift_stg2_sop_reader_cond_sub.sv
// -----------------------------------------------------------------------------
// lift_cond_sub
// Final lazy-reduction step: takes the low W bits of a wide word and
// subtracts q once if the value is >= q. Also flags any set bit above the
// residue field. Purely combinational.
//   d_i         : wide input word (W_IN bits)
//   q_i         : modulus (W bits)
//   res_o       : reduced residue (W bits)
//   range_err_o : 1 when d_i[W_IN-1:W] is nonzero
// -----------------------------------------------------------------------------
module lift_cond_sub
  import lift_stg2_pkg::*;
#(
  parameter int W_IN = DW,
  parameter int W    = RW
) (
  input  logic [W_IN-1:0] d_i,
  input  logic [W-1:0]    q_i,
  output logic [W-1:0]    res_o,
  output logic            range_err_o
);

  logic [W-1:0] v;

  assign v           = d_i[W-1:0];
  assign res_o       = (v >= q_i) ? (v - q_i) : v;
  assign range_err_o = |d_i[W_IN-1:W];

endmodule

// File: rtl/lift_stg2_sop_reader.sv
// -----------------------------------------------------------------------------
// lift_stg2_sop_reader
// Reads finished windows out of the stage-1 ping-pong SOP RAM word by word,
// forwards them on a valid/ready stream (optionally reducing to a residue
// mod Q) and releases each window back to stage 1 once its last word has
// been accepted.
//
// Ports:
//   CLK, RST_N         : clock, synchronous active-low reset
//   WIN_DONE, WIN_SEL  : stage 1 finished writing window WIN_SEL (pulse)
//   NUM_WORDS, MODE    : window length (0 = 8) and mode, sampled at start
//   Q                  : residue modulus, stable while BUSY
//   RD_WINDOW_2, RD_RESULT_ADDR_2, D_OUT_SOP_2 : stage-1 RAM read port
//   m_if (master)      : output stream M_DATA/M_VALID/M_READY/M_LAST/M_WIN
//   WIN_FREE, WIN_FREE_ID : window release pulse and index
//   BUSY               : FSM not idle
//   ERR_OVR, ERR_RANGE : sticky overrun / residue range errors
//   CHKSUM             : per-window XOR fold, present only with
//                        LIFT_STG2_CHECKSUM_EN defined
// -----------------------------------------------------------------------------
module lift_stg2_sop_reader
  import lift_stg2_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 WIN_DONE,
  input  logic                 WIN_SEL,
  input  logic [3:0]           NUM_WORDS,
  input  logic                 MODE,
  input  logic [RW-1:0]        Q,
  output logic                 RD_WINDOW_2,
  output logic [AW-1:0]        RD_RESULT_ADDR_2,
  input  logic [DW-1:0]        D_OUT_SOP_2,
  lift_stg2_sop_reader_if.master m_if,
  output logic                 WIN_FREE,
  output logic                 WIN_FREE_ID,
  output logic                 BUSY,
  output logic                 ERR_OVR,
`ifdef LIFT_STG2_CHECKSUM_EN
  output logic [RW-1:0]        CHKSUM,
`endif
  output logic                 ERR_RANGE
);

  state_e          state_q, state_d;
  logic [1:0]      pending_q, pending_d;
  logic            cur_win_q, cur_win_d;
  logic            last_served_q, last_served_d;
  logic            mode_q, mode_d;
  logic [AW-1:0]   last_addr_q, last_addr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   m_data_q, m_data_d;
  logic            m_valid_q, m_valid_d;
  logic            m_last_q, m_last_d;
  logic            m_win_q, m_win_d;
  logic            win_free_q, win_free_d;
  logic            win_free_id_q, win_free_id_d;
  logic            err_ovr_q, err_ovr_d;
  logic            err_range_q, err_range_d;

  logic            win_start;
  logic            pick_win;
  logic            load;
  logic            done_ok;
  logic [RW-1:0]   res;
  logic            range_err;
  logic [DW-1:0]   word_d;

  lift_cond_sub #(.W_IN(DW), .W(RW)) u_cond_sub (
    .d_i        (D_OUT_SOP_2),
    .q_i        (Q),
    .res_o      (res),
    .range_err_o(range_err)
  );

  assign word_d    = (mode_q == MODE_RES) ? {{(DW-RW){1'b0}}, res} : D_OUT_SOP_2;
  assign win_start = (state_q == ST_IDLE) && (|pending_q);
  // With both windows pending, alternate away from the one served last.
  assign pick_win  = (&pending_q) ? ~last_served_q : pending_q[1];
  assign load      = !m_valid_q || m_if.M_READY;
  // A request for a window that is already pending or currently being read
  // would overwrite data still owned by this block.
  assign done_ok   = !pending_q[WIN_SEL] &&
                     !((state_q != ST_IDLE) && (WIN_SEL == cur_win_q));

  always_comb begin
    // NOTE: every next-state signal takes its hold value before any branch,
    // so no path through this block leaves one unassigned (no latches).
    state_d       = state_q;
    pending_d     = pending_q;
    cur_win_d     = cur_win_q;
    last_served_d = last_served_q;
    mode_d        = mode_q;
    last_addr_d   = last_addr_q;
    addr_d        = addr_q;
    m_data_d      = m_data_q;
    m_valid_d     = m_valid_q;
    m_last_d      = m_last_q;
    m_win_d       = m_win_q;
    win_free_d    = 1'b0;
    win_free_id_d = win_free_id_q;
    err_ovr_d     = err_ovr_q;
    err_range_d   = err_range_q;

    case (state_q)
      ST_IDLE: begin
        if (win_start) begin
          cur_win_d     = pick_win;
          last_served_d = pick_win;
          mode_d        = MODE;
          // 0 and 8 both mean a full window.
          last_addr_d   = (NUM_WORDS[3] || NUM_WORDS[2:0] == 3'd0) ?
                          AW'(MAX_WORDS - 1) : NUM_WORDS[2:0] - 3'd1;
          addr_d        = '0;
          state_d       = ST_READ;
        end
      end
      ST_READ: begin
        if (load) begin
          m_data_d  = word_d;
          m_valid_d = 1'b1;
          m_last_d  = (addr_q == last_addr_q);
          m_win_d   = cur_win_q;
          addr_d    = addr_q + 3'd1;
          if ((mode_q == MODE_RES) && range_err) err_range_d = 1'b1;
          if (addr_q == last_addr_q) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (m_valid_q && m_if.M_READY && m_last_q) begin
          m_valid_d            = 1'b0;
          pending_d[cur_win_q] = 1'b0;
          win_free_d           = 1'b1;
          win_free_id_d        = cur_win_q;
          state_d              = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Applied after the release clear so a set of the other window in the
    // same cycle survives.
    if (WIN_DONE) begin
      if (done_ok) pending_d[WIN_SEL] = 1'b1;
      else         err_ovr_d          = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q       <= ST_IDLE;
      pending_q     <= '0;
      cur_win_q     <= 1'b0;
      last_served_q <= 1'b1;  // first tie-break after reset picks window 0
      mode_q        <= MODE_RAW;
      last_addr_q   <= '0;
      addr_q        <= '0;
      m_data_q      <= '0;
      m_valid_q     <= 1'b0;
      m_last_q      <= 1'b0;
      m_win_q       <= 1'b0;
      win_free_q    <= 1'b0;
      win_free_id_q <= 1'b0;
      err_ovr_q     <= 1'b0;
      err_range_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      cur_win_q     <= cur_win_d;
      last_served_q <= last_served_d;
      mode_q        <= mode_d;
      last_addr_q   <= last_addr_d;
      addr_q        <= addr_d;
      m_data_q      <= m_data_d;
      m_valid_q     <= m_valid_d;
      m_last_q      <= m_last_d;
      m_win_q       <= m_win_d;
      win_free_q    <= win_free_d;
      win_free_id_q <= win_free_id_d;
      err_ovr_q     <= err_ovr_d;
      err_range_q   <= err_range_d;
    end
  end

`ifdef LIFT_STG2_CHECKSUM_EN
  logic [RW-1:0] chk_q;

  // Cleared at window start, folded on every accepted word; holds the full
  // window value through the WIN_FREE cycle.
  always_ff @(posedge CLK) begin
    if (!RST_N)                                chk_q <= '0;
    else if (win_start)                        chk_q <= '0;
    else if (m_valid_q && m_if.M_READY)        chk_q <= chk_q ^ chk_fold(m_data_q);
  end

  assign CHKSUM = chk_q;
`endif

  assign RD_WINDOW_2      = cur_win_q;
  assign RD_RESULT_ADDR_2 = addr_q;
  assign m_if.M_DATA      = m_data_q;
  assign m_if.M_VALID     = m_valid_q;
  assign m_if.M_LAST      = m_last_q;
  assign m_if.M_WIN       = m_win_q;
  assign WIN_FREE         = win_free_q;
  assign WIN_FREE_ID      = win_free_id_q;
  assign BUSY             = (state_q != ST_IDLE);
  assign ERR_OVR          = err_ovr_q;
  assign ERR_RANGE        = err_range_q;

endmodule

// File: tb/tb_lift_stg2_sop_reader.sv
// -----------------------------------------------------------------------------
// tb_lift_stg2_sop_reader
// Directed bench for lift_stg2_sop_reader: reset, raw window, residue mode,
// backpressure, ping-pong with overrun, and mid-window reset. The stage-1
// RAM is a small array read asynchronously through the DUT's read port.
// Define LIFT_STG2_CHECKSUM_EN to also check CHKSUM.
// -----------------------------------------------------------------------------
module tb_lift_stg2_sop_reader;
  import lift_stg2_pkg::*;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          WIN_DONE;
  logic          WIN_SEL;
  logic [3:0]    NUM_WORDS;
  logic          MODE;
  logic [RW-1:0] Q;
  logic          RD_WINDOW_2;
  logic [AW-1:0] RD_RESULT_ADDR_2;
  logic [DW-1:0] D_OUT_SOP_2;
  logic          WIN_FREE;
  logic          WIN_FREE_ID;
  logic          BUSY;
  logic          ERR_OVR;
  logic          ERR_RANGE;
`ifdef LIFT_STG2_CHECKSUM_EN
  logic [RW-1:0] CHKSUM;
  logic [RW-1:0] chk_model;
`endif

  lift_stg2_sop_reader_if m_if ();

  lift_stg2_sop_reader dut (
    .CLK             (CLK),
    .RST_N           (RST_N),
    .WIN_DONE        (WIN_DONE),
    .WIN_SEL         (WIN_SEL),
    .NUM_WORDS       (NUM_WORDS),
    .MODE            (MODE),
    .Q               (Q),
    .RD_WINDOW_2     (RD_WINDOW_2),
    .RD_RESULT_ADDR_2(RD_RESULT_ADDR_2),
    .D_OUT_SOP_2     (D_OUT_SOP_2),
    .m_if            (m_if),
    .WIN_FREE        (WIN_FREE),
    .WIN_FREE_ID     (WIN_FREE_ID),
    .BUSY            (BUSY),
    .ERR_OVR         (ERR_OVR),
`ifdef LIFT_STG2_CHECKSUM_EN
    .CHKSUM          (CHKSUM),
`endif
    .ERR_RANGE       (ERR_RANGE)
  );

  always #5 CLK = ~CLK;

  logic [DW-1:0] mem [2][8];
  assign D_OUT_SOP_2 = mem[RD_WINDOW_2][RD_RESULT_ADDR_2];

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] got_data [$];
  bit            got_last [$];
  bit            got_win  [$];
  bit            free_ids [$];
  bit            stall_prev;
  logic [DW-1:0] prev_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_obs();
    got_data.delete();
    got_last.delete();
    got_win.delete();
    free_ids.delete();
    stall_prev = 1'b0;
    prev_data  = '0;
  endtask

`ifdef LIFT_STG2_CHECKSUM_EN
  function automatic logic [RW-1:0] tb_fold(input logic [DW-1:0] w);
    logic [RW-1:0] r;
    r = w[29:0];
    r = r ^ w[59:30];
    r = r ^ RW'(w[62:60]);
    return r;
  endfunction
`endif

  // One cycle at posedge+1: drive inputs, observe registered outputs,
  // record handshakes and releases, then advance to the next posedge+1.
  task automatic drive_cycle(input bit rdy, input bit wd, input bit ws);
    m_if.M_READY = rdy;
    WIN_DONE     = wd;
    WIN_SEL      = ws;
    if (WIN_FREE) begin
      free_ids.push_back(WIN_FREE_ID);
`ifdef LIFT_STG2_CHECKSUM_EN
      check("chksum", CHKSUM, chk_model);
      chk_model = '0;
`endif
    end
    if (stall_prev && m_if.M_VALID) check("stall_hold", m_if.M_DATA, prev_data);
    if (m_if.M_VALID && rdy) begin
      got_data.push_back(m_if.M_DATA);
      got_last.push_back(m_if.M_LAST);
      got_win.push_back(m_if.M_WIN);
`ifdef LIFT_STG2_CHECKSUM_EN
      chk_model = chk_model ^ tb_fold(m_if.M_DATA);
`endif
    end
    stall_prev = m_if.M_VALID && !rdy;
    prev_data  = m_if.M_DATA;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    RST_N        = 1'b0;
    WIN_DONE     = 1'b1;
    WIN_SEL      = 1'b0;
    MODE         = 1'b0;
    NUM_WORDS    = 4'd8;
    Q            = '0;
    m_if.M_READY = 1'b0;
`ifdef LIFT_STG2_CHECKSUM_EN
    chk_model    = '0;
`endif
    for (int k = 0; k < 8; k++) begin
      mem[0][k] = (63'd1 << 62) | 63'(k);
      mem[1][k] = 63'h0ABC_0000 + 63'(k);
    end
    clear_obs();

    // ---- Reset held 3 cycles with WIN_DONE asserted ----
    repeat (3) @(posedge CLK);
    #1;
    check("rst_valid", m_if.M_VALID, 0);
    check("rst_data", m_if.M_DATA, 0);
    check("rst_last", m_if.M_LAST, 0);
    check("rst_win", m_if.M_WIN, 0);
    check("rst_free", WIN_FREE, 0);
    check("rst_free_id", WIN_FREE_ID, 0);
    check("rst_busy", BUSY, 0);
    check("rst_ovr", ERR_OVR, 0);
    check("rst_range", ERR_RANGE, 0);
    check("rst_rdwin", RD_WINDOW_2, 0);
    check("rst_rdaddr", RD_RESULT_ADDR_2, 0);
    WIN_DONE = 1'b0;
    RST_N    = 1'b1;
    repeat (4) tick();
    check("post_rst_busy", BUSY, 0);
    check("post_rst_valid", m_if.M_VALID, 0);

    // ---- Raw single window, 8 words, exact latency ----
    MODE = MODE_RAW; NUM_WORDS = 4'd8; m_if.M_READY = 1'b1;
    WIN_DONE = 1'b1; WIN_SEL = 1'b0;
    tick();                         // E0 samples WIN_DONE
    WIN_DONE = 1'b0;
    check("raw_e0_valid", m_if.M_VALID, 0);
    check("raw_e0_busy", BUSY, 0);
    tick();                         // E1: READ
    check("raw_e1_busy", BUSY, 1);
    check("raw_e1_valid", m_if.M_VALID, 0);
    check("raw_e1_addr", RD_RESULT_ADDR_2, 0);
    tick();                         // E2: word 0 registered
    for (int k = 0; k < 8; k++) begin
      check($sformatf("raw_valid%0d", k), m_if.M_VALID, 1);
      check($sformatf("raw_data%0d", k), m_if.M_DATA, (64'd1 << 62) | 64'(k));
      check($sformatf("raw_last%0d", k), m_if.M_LAST, (k == 7) ? 1 : 0);
      check($sformatf("raw_win%0d", k), m_if.M_WIN, 0);
      tick();
    end
    check("raw_end_valid", m_if.M_VALID, 0);
    check("raw_free", WIN_FREE, 1);
    check("raw_free_id", WIN_FREE_ID, 0);
`ifdef LIFT_STG2_CHECKSUM_EN
    // Fold of (1<<62)|k over k=0..7: each word folds to 4^k.
    begin
      logic [RW-1:0] e;
      e = '0;
      for (int k = 0; k < 8; k++) e = e ^ (RW'(4) ^ RW'(k));
      check("raw_chksum", CHKSUM, e);
    end
`endif
    tick();
    check("raw_free_pulse", WIN_FREE, 0);
    check("raw_range", ERR_RANGE, 0);

    // ---- Residue mode on window 1 ----
    mem[1][0] = 63'd1073479690;
    mem[1][1] = 63'd5;
    mem[1][2] = (63'd1 << 40) | 63'd7;
    MODE = MODE_RES; NUM_WORDS = 4'd3; Q = 30'd1073479681;
    clear_obs();
    for (int i = 0; i < 30 && free_ids.size() < 1; i++) drive_cycle(1'b1, i == 0, 1'b1);
    check("res_count", got_data.size(), 3);
    if (got_data.size() == 3) begin
      check("res_data0", got_data[0], 9);
      check("res_data1", got_data[1], 5);
      check("res_data2", got_data[2], 7);
      check("res_last0", got_last[0], 0);
      check("res_last2", got_last[2], 1);
      check("res_win", got_win[1], 1);
    end
    check("res_free_n", free_ids.size(), 1);
    if (free_ids.size() == 1) check("res_free_id", free_ids[0], 1);
    check("res_range", ERR_RANGE, 1);
    check("res_ovr", ERR_OVR, 0);

    // ---- Backpressure: ready 1,0,1,0..., 4 words from window 0 ----
    MODE = MODE_RAW; NUM_WORDS = 4'd4;
    clear_obs();
    for (int i = 0; i < 60 && free_ids.size() < 1; i++)
      drive_cycle((i % 2) == 0, i == 0, 1'b0);
    check("bp_count", got_data.size(), 4);
    for (int k = 0; k < 4 && k < got_data.size(); k++) begin
      check($sformatf("bp_data%0d", k), got_data[k], (64'd1 << 62) | 64'(k));
      check($sformatf("bp_last%0d", k), got_last[k], (k == 3) ? 1 : 0);
    end
    check("bp_free_n", free_ids.size(), 1);
    check("bp_range_sticky", ERR_RANGE, 1);
    check("bp_ovr", ERR_OVR, 0);

    // ---- Ping-pong with overrun ----
    for (int k = 0; k < 8; k++) mem[1][k] = 63'h0ABC_0000 + 63'(k);
    NUM_WORDS = 4'd8;
    clear_obs();
    for (int i = 0; i < 60; i++)
      drive_cycle(1'b1, (i == 0) || (i == 1) || (i == 4), i == 1);
    check("pp_count", got_data.size(), 16);
    for (int k = 0; k < 16 && k < got_data.size(); k++) begin
      check($sformatf("pp_data%0d", k), got_data[k], {1'b0, mem[k / 8][k % 8]});
      check($sformatf("pp_win%0d", k), got_win[k], k / 8);
    end
    check("pp_free_n", free_ids.size(), 2);
    if (free_ids.size() == 2) begin
      check("pp_free_id0", free_ids[0], 0);
      check("pp_free_id1", free_ids[1], 1);
    end
    check("pp_ovr", ERR_OVR, 1);

    // ---- Mid-window reset ----
    NUM_WORDS = 4'd8;
    clear_obs();
    for (int i = 0; i < 30 && got_data.size() < 3; i++) drive_cycle(1'b1, i == 0, 1'b0);
    check("mid_words_before", got_data.size(), 3);
    RST_N = 1'b0;
    tick();
`ifdef LIFT_STG2_CHECKSUM_EN
    chk_model = '0;
`endif
    check("mid_rst_valid", m_if.M_VALID, 0);
    check("mid_rst_data", m_if.M_DATA, 0);
    check("mid_rst_busy", BUSY, 0);
    check("mid_rst_free", WIN_FREE, 0);
    check("mid_rst_ovr", ERR_OVR, 0);
    check("mid_rst_range", ERR_RANGE, 0);
    check("mid_rst_addr", RD_RESULT_ADDR_2, 0);
    RST_N = 1'b1;
    clear_obs();
    for (int i = 0; i < 6; i++) drive_cycle(1'b1, 1'b0, 1'b0);
    check("mid_no_free", free_ids.size(), 0);
    check("mid_no_words", got_data.size(), 0);
    NUM_WORDS = 4'd2;
    for (int i = 0; i < 30 && free_ids.size() < 1; i++) drive_cycle(1'b1, i == 0, 1'b1);
    check("mid_new_count", got_data.size(), 2);
    if (got_data.size() == 2) begin
      check("mid_new_data0", got_data[0], {1'b0, mem[1][0]});
      check("mid_new_data1", got_data[1], {1'b0, mem[1][1]});
      check("mid_new_win", got_win[0], 1);
    end
    check("mid_new_free_n", free_ids.size(), 1);
    if (free_ids.size() == 1) check("mid_new_free_id", free_ids[0], 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lift_stg2_sop_reader.md
Name: lift_stg2_sop_reader

Overview:
- Downstream consumer of the LIFT stage-1 datapath's 63-bit secondary output RAM.
- Stage 1 writes one window at a time into a ping-pong pair; this block reads each finished window word-by-word and forwards it on a valid/ready stream.
- In residue mode it applies the final lazy-reduction step (conditional subtract of q).
- It then hands the window back to stage 1 for reuse.

Parameters:
- DW, 63, width of a stored SOP word
- RW, 30, residue width
- AW, 3, word address width within a window
- MAX_WORDS, 8, words per window (2**AW)

Ports:
- CLK  in  1  clock, all logic on rising edge
- RST_N  in  1  synchronous active-low reset
- WIN_DONE  in  1  one-cycle pulse: stage 1 finished writing window WIN_SEL
- WIN_SEL  in  1  window index for WIN_DONE
- NUM_WORDS  in  4  words in window, 1..8; 0 treated as 8; sampled at window start
- MODE  in  1  0 = raw 63-bit pass-through, 1 = residue mode; sampled at window start
- Q  in  30  modulus for residue mode; held stable while BUSY
- RD_WINDOW_2  out  1  window select to stage-1 RAM read port
- RD_RESULT_ADDR_2  out  3  word address to stage-1 RAM read port
- D_OUT_SOP_2  in  63  asynchronous read data from stage-1 RAM
- M_DATA  out  63  output word
- M_VALID  out  1  output valid
- M_READY  in  1  downstream ready
- M_LAST  out  1  marks last word of window
- M_WIN  out  1  window the current word came from
- WIN_FREE  out  1  one-cycle pulse: window WIN_FREE_ID released
- WIN_FREE_ID  out  1  released window index
- BUSY  out  1  FSM not in IDLE
- ERR_OVR  out  1  sticky: WIN_DONE hit an already-pending window
- ERR_RANGE  out  1  sticky: residue mode saw nonzero D_OUT_SOP_2[62:30]

Behaviour:
- Reset (RST_N=0 at an edge): all outputs 0, FSM IDLE, pending[1:0]=0, address 0. This holds mid-window too: the partial window is discarded and no WIN_FREE is issued.
- Pending flags:
  - WIN_DONE sets pending[WIN_SEL].
  - If that flag is already set, or WIN_SEL equals the window currently being read, set ERR_OVR and ignore the request.
  - Clearing pending[cur] at release and setting the other flag in the same cycle both take effect.
- FSM states: IDLE, READ, DRAIN.
  - IDLE: if any pending bit is set, select a window. When both are set, take the one opposite the last window served; after reset, window 0. Latch cur_win, MODE and NUM_WORDS, set addr=0, go to READ.
  - READ: RD_WINDOW_2=cur_win, RD_RESULT_ADDR_2=addr. The output register loads when !M_VALID || M_READY; each load increments addr. The load of word NUM_WORDS-1 sets M_LAST and moves to DRAIN.
  - DRAIN: on the M_VALID && M_READY && M_LAST handshake, clear M_VALID, clear pending[cur_win], pulse WIN_FREE with WIN_FREE_ID=cur_win in the following cycle, go to IDLE.
- Latency:
  - WIN_DONE sampled at edge E0 → pending at E0, READ at E1, word 0 registered and M_VALID=1 after E2.
  - Throughput is 1 word/cycle with M_READY=1; there is a 2-cycle bubble between windows.
- Stall: M_DATA, M_LAST and M_WIN hold while M_VALID && !M_READY.
- Arithmetic:
  - MODE 0: M_DATA = D_OUT_SOP_2.
  - MODE 1: v = D[29:0]; M_DATA = {33'b0, (v >= Q) ? v - Q : v}. If D[62:30] != 0, set ERR_RANGE and still output the computed value.

Optional Feature:
- Macro LIFT_STG2_CHECKSUM_EN.
- When defined: add output CHKSUM (RW bits). It is an XOR-fold of each emitted word (M_DATA[29:0] ^ M_DATA[59:30] ^ {27'b0, M_DATA[62:60]}), accumulated over a window's handshakes. It is valid in the WIN_FREE cycle, cleared at window start, and 0 after reset.
- When undefined: the port and its logic are absent.

Decomposition:
- Package lift_stg2_pkg:
  - state enum
  - DW, RW, AW, MAX_WORDS constants
  - MODE_RAW=0 and MODE_RES=1
- One natural sub-module, lift_cond_sub: combinational v >= Q subtract plus upper-bits range flag; reusable in other lift stages.

Test Plan:
- Reset: hold RST_N=0 for 3 cycles with WIN_DONE=1 → all outputs 0; no pending window after release.
- Raw single window: MODE=0, NUM_WORDS=8, word k = (1<<62)|k, M_READY=1, WIN_DONE/WIN_SEL=0 → 8 consecutive words starting 2 edges later, M_LAST on k=7, WIN_FREE=1 with WIN_FREE_ID=0 for one cycle next.
- Residue mode: Q=1073479681, words 1073479690, 5, (1<<40)|7 → M_DATA 9, 5, 7; ERR_RANGE=1 after third word and stays 1.
- Backpressure: M_READY pattern 1,0,1,0,... with NUM_WORDS=4 → exactly 4 handshakes in order, M_DATA stable during stalls, no duplicates.
- Ping-pong and overrun: WIN_DONE sel 0, then sel 1 one cycle later, then sel 0 again while window 0 is being read → windows served 0 then 1, ERR_OVR=1, two WIN_FREE pulses total.
- Mid-window reset: RST_N=0 after word 2 of 8 → outputs 0, no WIN_FREE; a new WIN_DONE sel 1 afterwards streams from address 0.
